// File: rtl/pc_fetch_ctrl_if.sv
// ============================================================================
// Module : pc_fetch_ctrl_if
// Brief  : Fetch-side bundle between the PC sequencer and core/imem/adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_ctrl_if #(
  parameter int SIZE = 32
);
  logic            stall;
  logic            redirect;
  logic [SIZE-1:0] redirect_target;
  logic [SIZE-1:0] pc_plus4;
  logic            imem_ack;
  logic [SIZE-1:0] pc;
  logic            imem_req;
  logic            instr_valid;
  logic            trap;
  logic [SIZE-1:0] trap_pc;

  // master = the PC sequencer, slave = its environment
  modport master (
    input  stall, redirect, redirect_target, pc_plus4, imem_ack,
    output pc, imem_req, instr_valid, trap, trap_pc
  );

  modport slave (
    output stall, redirect, redirect_target, pc_plus4, imem_ack,
    input  pc, imem_req, instr_valid, trap, trap_pc
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module : pc_fetch_ctrl
// Brief  : RV32I program-counter register and fetch handshake sequencer.
//          Optional misaligned-target trap enabled by `define MISALIGN_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VECTOR = '0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pc_fetch_ctrl_if.master    bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef MISALIGN_TRAP_EN
  localparam logic [1:0] S_TRAP  = 2'd3;
`endif

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_pend_v;
  logic [SIZE-1:0] r_pend_tgt;
  logic            w_advance;
  logic            w_has_tgt;
  logic [SIZE-1:0] w_tgt;
  logic [SIZE-1:0] w_next_pc;
  logic            w_misalign;

  assign w_advance = ((r_state == S_FETCH) && bus.imem_ack && !bus.stall) ||
                     ((r_state == S_WAIT)  && !bus.stall);
  assign w_has_tgt = bus.redirect || r_pend_v;
  assign w_tgt     = bus.redirect ? bus.redirect_target : r_pend_tgt;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_has_tgt && (w_tgt[1:0] != 2'b00);
  assign w_next_pc  = w_has_tgt ? w_tgt : bus.pc_plus4;
`else
  // Without the trap, low target bits are simply dropped to keep pc word-aligned
  localparam logic [SIZE-1:0] c_ALIGN_MASK = {{(SIZE-2){1'b1}}, 2'b00};
  assign w_misalign = 1'b0;
  assign w_next_pc  = w_has_tgt ? (w_tgt & c_ALIGN_MASK) : bus.pc_plus4;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack && bus.stall)
          w_state_nxt = S_WAIT;
`ifdef MISALIGN_TRAP_EN
        else if (w_advance && w_misalign)
          w_state_nxt = S_TRAP;
`endif
      end
      S_WAIT: begin
        if (!bus.stall) begin
`ifdef MISALIGN_TRAP_EN
          w_state_nxt = w_misalign ? S_TRAP : S_FETCH;
`else
          w_state_nxt = S_FETCH;
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_TRAP:  w_state_nxt = S_TRAP;
`endif
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req = (r_state == S_FETCH);
`ifdef MISALIGN_TRAP_EN
    bus.trap     = (r_state == S_TRAP);
`else
    bus.trap     = 1'b0;
`endif
  end

  // PC, pending redirect and the accepted-instruction pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pc          <= RESET_VECTOR;
      bus.instr_valid <= 1'b0;
      r_pend_v        <= 1'b0;
      r_pend_tgt      <= '0;
    end else begin
      bus.instr_valid <= w_advance;
      if (w_advance) begin
        r_pend_v <= 1'b0;
        if (!w_misalign)
          bus.pc <= w_next_pc;
      end else if (((r_state == S_FETCH) || (r_state == S_WAIT)) && bus.redirect) begin
        r_pend_v   <= 1'b1;
        r_pend_tgt <= bus.redirect_target;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.trap_pc <= '0;
    else if (w_advance && w_misalign)
      bus.trap_pc <= w_tgt;
  end
`else
  assign bus.trap_pc = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// Module : tb_pc_fetch_ctrl
// Brief  : Directed + randomized bench for pc_fetch_ctrl against a cycle model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.SIZE(32)) bus ();

  // The external PC+4 adder
  assign bus.pc_plus4 = bus.pc + 32'd4;

  pc_fetch_ctrl #(.SIZE(32), .RESET_VECTOR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: phase 0=boot 1=fetching 2=waiting 3=trapped
  int          m_phase;
  logic [31:0] m_pc, m_tgt_q, m_trap_pc;
  logic        m_pend, m_iv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pc <= 32'h0; m_pend <= 1'b0; m_tgt_q <= 32'h0;
      m_iv <= 1'b0; m_trap_pc <= 32'h0;
    end else begin
      automatic bit accept = (m_phase == 1 && bus.imem_ack && !bus.stall) ||
                             (m_phase == 2 && !bus.stall);
      automatic bit use_t  = bus.redirect || m_pend;
      automatic logic [31:0] t = bus.redirect ? bus.redirect_target : m_tgt_q;
      m_iv <= accept;
      if (m_phase == 0) m_phase <= 1;
      if (m_phase == 1 && bus.imem_ack && bus.stall) m_phase <= 2;
      if (accept) begin
        m_pend  <= 1'b0;
        m_phase <= 1;
        if (!use_t) m_pc <= m_pc + 32'd4;
`ifdef MISALIGN_TRAP_EN
        else if (t % 4 != 0) begin m_phase <= 3; m_trap_pc <= t; end
        else m_pc <= t;
`else
        else m_pc <= t - (t % 4);
`endif
      end else if ((m_phase == 1 || m_phase == 2) && bus.redirect) begin
        m_pend  <= 1'b1;
        m_tgt_q <= bus.redirect_target;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("pc",          bus.pc,                   m_pc);
    check("imem_req",    {31'b0, bus.imem_req},    {31'b0, m_phase == 1});
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_iv});
    check("trap",        {31'b0, bus.trap},        {31'b0, m_phase == 3});
    check("trap_pc",     bus.trap_pc,              m_trap_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0; bus.imem_ack = 0;

    // Reset, then back-to-back fetches
    repeat (3) tick();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_iv", {31'b0, bus.instr_valid}, 32'h0);
    rst_n = 1; bus.imem_ack = 1;
    check("boot_req", {31'b0, bus.imem_req}, 32'h0);
    tick(); check("t1_pc0", bus.pc, 32'h0); check("t1_req", {31'b0, bus.imem_req}, 32'h1);
    tick(); check("t1_pc4", bus.pc, 32'h4); check("t1_iv", {31'b0, bus.instr_valid}, 32'h1);
    tick(); check("t1_pc8", bus.pc, 32'h8);
    tick(); check("t1_pcC", bus.pc, 32'hC);

    // Slow memory: hold two cycles, one pulse per ack
    bus.imem_ack = 0;
    tick(); check("t2_hold", bus.pc, 32'hC); check("t2_iv0", {31'b0, bus.instr_valid}, 32'h0);
    tick(); check("t2_hold2", bus.pc, 32'hC);
    bus.imem_ack = 1;
    tick(); check("t2_pc10", bus.pc, 32'h10); check("t2_iv1", {31'b0, bus.instr_valid}, 32'h1);

    // Redirect while waiting for ack becomes pending
    bus.imem_ack = 0; bus.redirect = 1; bus.redirect_target = 32'h100;
    tick(); bus.redirect = 0; check("t3_hold", bus.pc, 32'h10);
    tick(); check("t3_hold2", bus.pc, 32'h10);
    bus.imem_ack = 1;
    tick(); check("t3_pend", bus.pc, 32'h100);

    // Stall on ack parks in WAIT
    bus.stall = 1;
    tick(); check("t4_req0", {31'b0, bus.imem_req}, 32'h0); check("t4_pc", bus.pc, 32'h100);
    bus.imem_ack = 0;
    repeat (3) tick();
    check("t4_still", bus.pc, 32'h100); check("t4_req0b", {31'b0, bus.imem_req}, 32'h0);
    bus.stall = 0;
    tick(); check("t4_pc104", bus.pc, 32'h104); check("t4_req1", {31'b0, bus.imem_req}, 32'h1);

    // Wrap at top of address space, then reset mid-WAIT with a pending redirect
    bus.imem_ack = 1; bus.redirect = 1; bus.redirect_target = 32'hFFFF_FFFC;
    tick(); bus.redirect = 0; check("t5_top", bus.pc, 32'hFFFF_FFFC);
    tick(); check("t5_wrap", bus.pc, 32'h0);
    bus.stall = 1;
    tick(); bus.imem_ack = 0; bus.redirect = 1; bus.redirect_target = 32'h200;
    tick(); bus.redirect = 0;
    rst_n = 0; #1;
    check("t5_rst_pc", bus.pc, 32'h0); check("t5_rst_req", {31'b0, bus.imem_req}, 32'h0);
    tick(); rst_n = 1; bus.stall = 0; bus.imem_ack = 1;
    tick(); tick(); check("t5_nopend", bus.pc, 32'h4);

    // Misaligned redirect target
    bus.redirect = 1; bus.redirect_target = 32'h102;
    tick(); bus.redirect = 0; bus.imem_ack = 0;
`ifdef MISALIGN_TRAP_EN
    check("t6_trap", {31'b0, bus.trap}, 32'h1); check("t6_trap_pc", bus.trap_pc, 32'h102);
    check("t6_req", {31'b0, bus.imem_req}, 32'h0); check("t6_pc", bus.pc, 32'h4);
`else
    check("t6_pc", bus.pc, 32'h100); check("t6_trap", {31'b0, bus.trap}, 32'h0);
`endif
    check("t6_iv", {31'b0, bus.instr_valid}, 32'h1);
    rst_n = 0; tick(); rst_n = 1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.imem_ack = ($urandom_range(0, 3) != 0);
      bus.stall    = ($urandom_range(0, 4) == 0);
      bus.redirect = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       bus.redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        1:       bus.redirect_target = $urandom;
        default: bus.redirect_target = $urandom & 32'h0000_FFFC;
      endcase
      rst_n = ($urandom_range(0, 150) != 0);
      tick();
    end
    rst_n = 1; bus.redirect = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
